// File: rtl/addsub_pkg.sv
// Shared definitions for the add/sub result display.
//   state_t      : display FSM states (IDLE, CONVERT, SHOW)
//   digit_t      : 4-bit digit code; 0..9 are decimal values, plus MINUS and BLANK
//   SEG_*        : 7-segment patterns, bit order gfedcba, active-high
//   to_units     : helper giving the decimal units digit of a 4-bit magnitude
package addsub_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CONVERT = 2'd1,
    ST_SHOW    = 2'd2
  } state_t;

  typedef logic [3:0] digit_t;

  localparam digit_t DIG_MINUS = 4'd10;
  localparam digit_t DIG_BLANK = 4'd11;

  localparam logic [6:0] SEG_0     = 7'h3F;
  localparam logic [6:0] SEG_1     = 7'h06;
  localparam logic [6:0] SEG_2     = 7'h5B;
  localparam logic [6:0] SEG_3     = 7'h4F;
  localparam logic [6:0] SEG_4     = 7'h66;
  localparam logic [6:0] SEG_5     = 7'h6D;
  localparam logic [6:0] SEG_6     = 7'h7D;
  localparam logic [6:0] SEG_7     = 7'h07;
  localparam logic [6:0] SEG_8     = 7'h7F;
  localparam logic [6:0] SEG_9     = 7'h6F;
  localparam logic [6:0] SEG_MINUS = 7'h40;
  localparam logic [6:0] SEG_BLANK = 7'h00;

  // Magnitude never exceeds 15, so a single conditional subtract is mod 10.
  function automatic digit_t to_units(input logic [3:0] mag);
    return (mag >= 4'd10) ? (mag - 4'd10) : mag;
  endfunction

endpackage

// File: rtl/seg7_decode.sv
// Combinational digit-code to 7-segment decoder.
//   digit : digit code (0..9, DIG_MINUS, DIG_BLANK)
//   seg   : segment pattern gfedcba, active-high; unknown codes show blank
module seg7_decode
  import addsub_pkg::*;
(
  input  digit_t     digit,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_BLANK;
    case (digit)
      4'd0:      seg = SEG_0;
      4'd1:      seg = SEG_1;
      4'd2:      seg = SEG_2;
      4'd3:      seg = SEG_3;
      4'd4:      seg = SEG_4;
      4'd5:      seg = SEG_5;
      4'd6:      seg = SEG_6;
      4'd7:      seg = SEG_7;
      4'd8:      seg = SEG_8;
      4'd9:      seg = SEG_9;
      DIG_MINUS: seg = SEG_MINUS;
      default:   seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/addsub_result_display.sv
// Consumer of the add/sub unit's result stream. Captures a sign-magnitude
// result, converts it to sign/tens/units digits, and scans them onto a
// three-digit multiplexed 7-segment display. Flags a sticky error when the
// producer's zero flag disagrees with the magnitude.
//   clk, rst_n     : clock, synchronous active-low reset
//   in_valid/ready : result handshake
//   result         : bit4 sign, bits 3:0 magnitude
//   zeroflag       : producer's zero indication
//   err_clr        : clears err_flag (a same-edge new mismatch still sets it)
//   seg, an        : segment pattern (gfedcba) and one-hot digit enable
//                    (an[0] units, an[1] tens, an[2] sign)
//   err_flag       : sticky zero-flag mismatch
//   dbg_state      : current FSM state, for observation only
//
// Handshake: a transfer happens on a rising edge where in_valid && in_ready.
// in_ready does not depend on in_valid; values offered while in_ready is low
// are dropped, never queued.
module addsub_result_display
  import addsub_pkg::*;
#(
  parameter int REFRESH_DIV    = 4,
  parameter bit SEG_ACTIVE_LOW = 1'b0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [4:0] result,
  input  logic       zeroflag,
  input  logic       err_clr,
  output logic [6:0] seg,
  output logic [2:0] an,
  output logic       err_flag,
  output state_t     dbg_state
);

  localparam int DIV_W = $clog2(REFRESH_DIV);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(REFRESH_DIV - 1);

  state_t           state_q,  state_d;
  logic [4:0]       result_q, result_d;
  logic             zero_q,   zero_d;
  digit_t           units_q,  units_d;
  digit_t           tens_q,   tens_d;
  digit_t           sign_q,   sign_d;
  logic             err_q,    err_d;
  logic [DIV_W-1:0] div_q,    div_d;
  logic [1:0]       scan_q,   scan_d;

  logic       accept;
  logic [3:0] mag;
  digit_t     scan_digit;
  logic [6:0] seg_raw;
  logic [2:0] an_raw;

  assign mag    = result_q[3:0];
  assign accept = in_valid && in_ready;

  // FSM, capture and conversion
  always_comb begin
    state_d  = state_q;
    result_d = result_q;
    zero_d   = zero_q;
    units_d  = units_q;
    tens_d   = tens_q;
    sign_d   = sign_q;
    err_d    = err_q;
    in_ready = 1'b1;

    if (err_clr) err_d = 1'b0;

    case (state_q)
      ST_IDLE, ST_SHOW: begin
        if (accept) begin
          result_d = result;
          zero_d   = zeroflag;
          state_d  = ST_CONVERT;
        end
      end
      ST_CONVERT: begin
        in_ready = 1'b0;
        units_d  = to_units(mag);
        tens_d   = (mag >= 4'd10) ? 4'd1 : DIG_BLANK;
        // Negative zero shows as plain 0, so the minus needs a non-zero magnitude.
        sign_d   = (result_q[4] && (mag != 4'd0)) ? DIG_MINUS : DIG_BLANK;
        // Placed after the clear so a same-edge mismatch wins.
        if (zero_q != (mag == 4'd0)) err_d = 1'b1;
        state_d  = ST_SHOW;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Free-running scan, independent of the FSM
  always_comb begin
    div_d  = div_q + 1'b1;
    scan_d = scan_q;
    if (div_q == DIV_LAST) begin
      div_d  = '0;
      scan_d = (scan_q == 2'd2) ? 2'd0 : scan_q + 2'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      result_q <= '0;
      zero_q   <= 1'b0;
      units_q  <= DIG_BLANK;
      tens_q   <= DIG_BLANK;
      sign_q   <= DIG_BLANK;
      err_q    <= 1'b0;
      div_q    <= '0;
      scan_q   <= 2'd0;
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      zero_q   <= zero_d;
      units_q  <= units_d;
      tens_q   <= tens_d;
      sign_q   <= sign_d;
      err_q    <= err_d;
      div_q    <= div_d;
      scan_q   <= scan_d;
    end
  end

  // Display path is purely from registered state
  always_comb begin
    scan_digit = units_q;
    an_raw     = 3'b001;
    case (scan_q)
      2'd1: begin scan_digit = tens_q; an_raw = 3'b010; end
      2'd2: begin scan_digit = sign_q; an_raw = 3'b100; end
      default: begin scan_digit = units_q; an_raw = 3'b001; end
    endcase
  end

  seg7_decode u_seg7_decode (
    .digit (scan_digit),
    .seg   (seg_raw)
  );

  assign seg       = SEG_ACTIVE_LOW ? ~seg_raw : seg_raw;
  assign an        = SEG_ACTIVE_LOW ? ~an_raw  : an_raw;
  assign err_flag  = err_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_addsub_result_display.sv
// Directed testbench for addsub_result_display (REFRESH_DIV=4, active-high).
module tb_addsub_result_display;
  import addsub_pkg::*;

  localparam int RDIV = 4;

  // Clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [4:0] result = '0;
  logic       zeroflag = 1'b0;
  logic       err_clr = 1'b0;
  logic [6:0] seg;
  logic [2:0] an;
  logic       err_flag;
  state_t     dbg_state;

  addsub_result_display #(.REFRESH_DIV(RDIV), .SEG_ACTIVE_LOW(1'b0)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .result    (result),
    .zeroflag  (zeroflag),
    .err_clr   (err_clr),
    .seg       (seg),
    .an        (an),
    .err_flag  (err_flag),
    .dbg_state (dbg_state)
  );

  int checks = 0;
  int errors = 0;

  // Reference edge count since reset: divider = cnt % RDIV, scan slot = (cnt / RDIV) % 3
  int cnt = 0;
  always @(posedge clk) begin
    if (!rst_n) cnt <= 0;
    else        cnt <= cnt + 1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // One full scan rotation, checking every slot against the expected digits.
  task automatic check_display(input string tag, input logic [6:0] u, input logic [6:0] t,
                               input logic [6:0] s, input logic exp_err);
    logic [2:0] exp_an;
    logic [6:0] exp_seg;
    for (int i = 0; i < 3 * RDIV; i++) begin
      tick();
      case ((cnt / RDIV) % 3)
        1:       begin exp_an = 3'b010; exp_seg = t; end
        2:       begin exp_an = 3'b100; exp_seg = s; end
        default: begin exp_an = 3'b001; exp_seg = u; end
      endcase
      chk({tag, "_an"},  32'(an),  32'(exp_an));
      chk({tag, "_seg"}, 32'(seg), 32'(exp_seg));
      chk({tag, "_err"}, 32'(err_flag), 32'(exp_err));
    end
  endtask

  // Single-cycle handshake, then check the CONVERT cycle and the return to ready.
  task automatic send(input string tag, input logic [4:0] r, input logic z, input logic exp_err);
    in_valid = 1'b1; result = r; zeroflag = z;
    chk({tag, "_rdy_pre"}, 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
    chk({tag, "_rdy_cvt"}, 32'(in_ready), 32'd0);
    chk({tag, "_st_cvt"},  32'(dbg_state), 32'(ST_CONVERT));
    tick();
    chk({tag, "_rdy_show"}, 32'(in_ready), 32'd1);
    chk({tag, "_st_show"},  32'(dbg_state), 32'(ST_SHOW));
    chk({tag, "_err_exit"}, 32'(err_flag), 32'(exp_err));
  endtask

  initial begin
    // Reset hold
    rst_n = 1'b0;
    repeat (3) tick();
    chk("rst_ready", 32'(in_ready), 32'd1);
    chk("rst_err",   32'(err_flag), 32'd0);
    chk("rst_an",    32'(an),       32'b001);
    chk("rst_seg",   32'(seg),      32'h00);
    chk("rst_state", 32'(dbg_state), 32'(ST_IDLE));
    rst_n = 1'b1;
    check_display("idle", 7'h00, 7'h00, 7'h00, 1'b0);

    // -6
    send("m6", 5'b10110, 1'b0, 1'b0);
    check_display("m6", 7'h7D, 7'h00, 7'h40, 1'b0);

    // +15
    send("p15", 5'b01111, 1'b0, 1'b0);
    check_display("p15", 7'h6D, 7'h06, 7'h00, 1'b0);

    // -0 shows as plain 0, no error
    send("m0", 5'b10000, 1'b1, 1'b0);
    check_display("m0", 7'h3F, 7'h00, 7'h00, 1'b0);

    // +3 with zeroflag set: mismatch, sticky until err_clr
    send("p3z", 5'b00011, 1'b1, 1'b1);
    check_display("p3z", 7'h4F, 7'h00, 7'h00, 1'b1);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    chk("clr_err", 32'(err_flag), 32'd0);

    // Clear held across a new mismatch: set wins on the CONVERT-exit edge
    err_clr = 1'b1;
    send("setwin", 5'b00011, 1'b1, 1'b1);
    tick();
    chk("setwin_clr", 32'(err_flag), 32'd0);
    err_clr = 1'b0;

    // Back-to-back: +5 offered during CONVERT is dropped
    in_valid = 1'b1; result = 5'b00010; zeroflag = 1'b0;
    tick();
    result = 5'b00101;
    chk("b2b_rdy_cvt", 32'(in_ready), 32'd0);
    tick();
    in_valid = 1'b0;
    chk("b2b_state", 32'(dbg_state), 32'(ST_SHOW));
    check_display("b2b", 7'h5B, 7'h00, 7'h00, 1'b0);
    send("m1", 5'b10001, 1'b0, 1'b0);
    check_display("m1", 7'h06, 7'h00, 7'h40, 1'b0);

    // +0 without zeroflag: mismatch in the other direction
    send("p0nz", 5'b00000, 1'b0, 1'b1);
    check_display("p0nz", 7'h3F, 7'h00, 7'h00, 1'b1);

    // Reset during CONVERT discards the capture and clears the error
    in_valid = 1'b1; result = 5'b01001; zeroflag = 1'b0;
    tick();
    in_valid = 1'b0;
    chk("rcv_state", 32'(dbg_state), 32'(ST_CONVERT));
    rst_n = 1'b0;
    tick();
    chk("rcv_ready", 32'(in_ready), 32'd1);
    chk("rcv_err",   32'(err_flag), 32'd0);
    chk("rcv_an",    32'(an),       32'b001);
    chk("rcv_seg",   32'(seg),      32'h00);
    chk("rcv_state2", 32'(dbg_state), 32'(ST_IDLE));
    rst_n = 1'b1;
    check_display("rcv", 7'h00, 7'h00, 7'h00, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Overall time bound
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/addsub_result_display.md
Name: addsub_result_display

Overview:
- Consumer end of the add/sub unit's output interface. Captures one result per valid/ready handshake:
  - 5-bit sign-magnitude result: bit4 is the sign, bits 3:0 are the magnitude.
  - zero flag.
- Converts the magnitude to decimal digits and time-multiplexes three 7-segment digits: sign, tens, units.
- Checks the incoming zero flag against the magnitude and raises a sticky error on mismatch.

Parameters:
- REFRESH_DIV, 4: clock cycles each digit stays enabled before the scan advances. Legal values are 2 and above. Use 4 for simulation and a large value on the board.
- SEG_ACTIVE_LOW, 0: when 1, the seg and an outputs are inverted at the port.

Ports:
- clk  in  1  system clock; every register updates on the rising edge.
- rst_n  in  1  synchronous, active-low reset, sampled on the rising edge of clk.
- in_valid  in  1  result and zeroflag are valid this cycle.
- in_ready  out  1  block can accept a result this cycle.
- result  in  5  sign-magnitude result: bit4 sign, bits 3:0 magnitude (0..15).
- zeroflag  in  1  producer's zero indication.
- err_clr  in  1  clears err_flag.
- seg  out  7  segment pattern, bit order gfedcba, active-high before the SEG_ACTIVE_LOW inversion.
- an  out  3  one-hot digit enable: an[0] units, an[1] tens, an[2] sign.
- err_flag  out  1  sticky zero-flag mismatch.

Behaviour:
- Reset values (rst_n low at a clock edge):
  - State is IDLE; all digit registers hold BLANK.
  - Divider and scan index are 0.
  - Outputs: in_ready=1, err_flag=0, an=3'b001, seg=7'h00 (all before inversion).
- FSM states:
  - IDLE: no value loaded; in_ready=1. A handshake (in_valid && in_ready) captures result and zeroflag and moves to CONVERT.
  - CONVERT: lasts exactly 1 cycle; in_ready=0.
    - Writes the digit registers.
    - Evaluates the error check.
    - Goes to SHOW.
  - SHOW: displays the stored value; in_ready=1. A handshake captures the new value and moves to CONVERT. The old digits stay displayed until CONVERT completes.
- Conversion rules, with mag = result[3:0]:
  - units = mag mod 10.
  - tens = 1 if mag >= 10; otherwise tens = BLANK (leading-zero blanking).
  - sign digit = MINUS only if result[4]=1 and mag != 0; otherwise BLANK. Negative zero displays as plain 0.
- Error check in CONVERT:
  - If zeroflag != (mag == 0), set err_flag on the CONVERT-exit edge.
  - err_flag holds until err_clr=1 at a clock edge.
  - If err_clr and a new mismatch land on the same edge, set wins.
- Latency: handshake at edge N, new digits visible from edge N+1. Any input with in_valid high while in_ready=0 is ignored, not queued.
- Scan:
  - The divider counts 0..REFRESH_DIV-1 continuously in every state, independent of the FSM.
  - When the divider wraps, the scan index advances 0→1→2→0.
  - an = one-hot of the scan index.
  - seg = decode of the digit selected by the scan index.
  - seg and an are combinational from registered state, so there are no glitches from the inputs.
- Segment codes (gfedcba): 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F, MINUS=40, BLANK=00.
- Reset mid-operation, including during CONVERT: everything returns to the reset values on that edge. The captured value is discarded.

Decomposition:
- Package addsub_pkg holds:
  - the state enum (IDLE, CONVERT, SHOW);
  - the digit codes (0–9 as values, plus DIG_MINUS and DIG_BLANK);
  - the 7-bit segment constants listed above.
- One combinational sub-module, seg7_decode (4-bit digit code → 7-bit seg), instantiated once on the scan-selected digit.
- The divider, scan counter and FSM live in the top.

Test Plan:
- Reset hold, then release; no input:
  - Expect in_ready=1, err_flag=0, an=001, seg=00.
  - an advances to 010 after REFRESH_DIV cycles and to 100 after 2*REFRESH_DIV; seg stays 00.
- result=5'b10110 (−6), zeroflag=0, one handshake:
  - One cycle later in_ready returns to 1.
  - Per scan slot: units 7D, tens 00, sign 40; err_flag=0.
- result=5'b01111 (+15), zeroflag=0:
  - Units 6D, tens 06, sign 00.
- result=5'b10000 (−0), zeroflag=1:
  - Units 3F, tens 00, sign 00; err_flag=0.
- result=5'b00011, zeroflag=1:
  - err_flag=1 from the edge after CONVERT and stays set while digits show 4F/00/00.
  - err_clr pulse → err_flag=0.
- Back-to-back: in_valid held high with +2, then +5 on the next cycle.
  - +5 arrives during CONVERT (in_ready=0) and is ignored; the display shows 5B.
  - A third value, −1, presented in SHOW is accepted: units 06, sign 40.
- rst_n asserted during CONVERT:
  - All outputs at reset values on the next edge; the display is blank.
